// File: rtl/psec6_spi_pkg.sv
// Shared types and constants for the PSEC6 SPI configuration sequencer:
// FSM states, frame geometry and the register-file address map.
package psec6_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_e;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;

    localparam logic [ADDR_W-1:0] ADDR_VCO_DIGITAL_BAND   = 7'd1;
    localparam logic [ADDR_W-1:0] ADDR_TRIGGER_MASK       = 7'd2;
    localparam logic [ADDR_W-1:0] ADDR_INSTRUCTION        = 7'd3;
    localparam logic [ADDR_W-1:0] ADDR_MODE               = 7'd4;
    localparam logic [ADDR_W-1:0] ADDR_ENABLE_CONTROL     = 7'd5;
    localparam logic [ADDR_W-1:0] ADDR_DAC_BIAS           = 7'd6;
    localparam logic [ADDR_W-1:0] ADDR_DAC_OFFSET         = 7'd7;
    localparam logic [ADDR_W-1:0] ADDR_PLL_DIVIDER        = 7'd8;
    localparam logic [ADDR_W-1:0] ADDR_PLL_SWITCH         = 7'd9;
    localparam logic [ADDR_W-1:0] ADDR_TEST_POINT_CONTROL = 7'd10;
    localparam logic [ADDR_W-1:0] ADDR_PLL_LOCKED         = 7'd11;

    localparam logic RW_WRITE = 1'b1;

    // Header byte {rw, addr} followed by the data byte; reads carry zeros.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic              rw,
                                                          input logic [ADDR_W-1:0] addr,
                                                          input logic [7:0]        data);
        return {rw, addr, (rw == RW_WRITE) ? data : 8'h00};
    endfunction

endpackage

// File: rtl/spi_edge_gen.sv
// Half-period divider that generates the internal spi_clk level and the
// one-cycle strobes marking the end of each low/high phase.
module spi_edge_gen
    import psec6_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic hold_low_i,
    output logic spi_clk_o,
    output logic phase_end_o,
    output logic rise_strobe_o,
    output logic fall_strobe_o,
    output logic sample_strobe_o
);

    localparam int               DIV_W    = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             level_q, level_d;

    // hold_low keeps the clock low across a phase boundary (SETUP and HOLD).
    always_comb begin
        phase_end_o     = en_i && (div_q == DIV_LAST);
        rise_strobe_o   = phase_end_o && !level_q && !hold_low_i;
        fall_strobe_o   = phase_end_o && level_q;
        sample_strobe_o = fall_strobe_o;
        div_d           = div_q;
        level_d         = level_q;
        if (!en_i) begin
            div_d   = '0;
            level_d = 1'b0;
        end else if (phase_end_o) begin
            div_d   = '0;
            level_d = rise_strobe_o;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            level_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            level_q <= level_d;
        end
    end

    assign spi_clk_o = level_q;

endmodule

// File: rtl/spi_cfg_sequencer.sv
// SPI master that turns single-register requests into 16-bit cs frames for
// the PSEC6 register file, with optional write-then-readback verification.
module spi_cfg_sequencer
    import psec6_spi_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_verify,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_mismatch,
    output logic              busy,
    output logic              spi_clk,
    output logic              cs,
    output logic              pico,
    input  logic              poci
);

    localparam int               GAP_W    = $clog2(GAP_CYCLES) + 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [4:0]       LAST_BIT = 5'(FRAME_BITS);
    localparam logic [4:0]       HDR_BITS = 5'(FRAME_BITS / 2);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [7:0]              wdata_q, wdata_d;
    logic                    write_q, write_d;
    logic                    verify_q, verify_d;
    logic                    rd_phase_q, rd_phase_d;
    logic                    again_q, again_d;
    logic                    done_q, done_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [7:0]              rdata_q, rdata_d;
    logic [4:0]              bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
    logic                    sample_q, sample_d;
    logic                    cs_q, cs_d;
    logic                    sclk_q, sclk_d;
    logic                    pico_q, pico_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [7:0]              rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_mismatch_q, rsp_mismatch_d;

    logic frame_on, edge_clk, phase_end, rise_strobe, fall_strobe, sample_strobe;

    assign frame_on = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);

    spi_edge_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_edge_gen (
        .clk             (clk),
        .rst             (rst),
        .en_i            (frame_on),
        .hold_low_i      ((state_q == ST_SETUP) || (state_q == ST_HOLD)),
        .spi_clk_o       (edge_clk),
        .phase_end_o     (phase_end),
        .rise_strobe_o   (rise_strobe),
        .fall_strobe_o   (fall_strobe),
        .sample_strobe_o (sample_strobe)
    );

    // Pins are registered one cycle behind the FSM, so poci capture and the
    // response are delayed by the same cycle to stay aligned with the pins.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        write_d        = write_q;
        verify_d       = verify_q;
        rd_phase_d     = rd_phase_q;
        again_d        = again_q;
        done_d         = 1'b0;
        shift_d        = shift_q;
        rdata_d        = rdata_q;
        bit_cnt_d      = bit_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        rsp_valid_d    = 1'b0;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_mismatch_d = rsp_mismatch_q;
        cs_d           = frame_on;
        sclk_d         = edge_clk;
        pico_d         = frame_on && shift_q[FRAME_BITS-1];
        sample_d       = (state_q == ST_SHIFT) && sample_strobe && (bit_cnt_q > HDR_BITS);

        if (sample_q) begin
            rdata_d = {rdata_q[6:0], poci};
        end
        if (done_q) begin
            rsp_valid_d    = 1'b1;
            rsp_rdata_d    = rdata_q;
            rsp_mismatch_d = write_q && verify_q && (rdata_q != wdata_q);
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d    = ST_SETUP;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    write_d    = req_write;
                    verify_d   = req_verify;
                    rd_phase_d = 1'b0;
                    again_d    = 1'b0;
                    shift_d    = build_frame(req_write, req_addr, req_wdata);
                    bit_cnt_d  = '0;
                end
            end
            ST_SETUP: begin
                if (phase_end) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (rise_strobe) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                if (fall_strobe) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (phase_end) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                    if (write_q && verify_q && !rd_phase_q) begin
                        again_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (again_q) begin
                        state_d    = ST_SETUP;
                        again_d    = 1'b0;
                        rd_phase_d = 1'b1;
                        shift_d    = build_frame(~RW_WRITE, addr_q, wdata_q);
                        bit_cnt_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            write_q        <= 1'b0;
            verify_q       <= 1'b0;
            rd_phase_q     <= 1'b0;
            again_q        <= 1'b0;
            done_q         <= 1'b0;
            shift_q        <= '0;
            rdata_q        <= '0;
            bit_cnt_q      <= '0;
            gap_cnt_q      <= '0;
            sample_q       <= 1'b0;
            cs_q           <= 1'b0;
            sclk_q         <= 1'b0;
            pico_q         <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= 8'h00;
            rsp_mismatch_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            write_q        <= write_d;
            verify_q       <= verify_d;
            rd_phase_q     <= rd_phase_d;
            again_q        <= again_d;
            done_q         <= done_d;
            shift_q        <= shift_d;
            rdata_q        <= rdata_d;
            bit_cnt_q      <= bit_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            sample_q       <= sample_d;
            cs_q           <= cs_d;
            sclk_q         <= sclk_d;
            pico_q         <= pico_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_mismatch_q <= rsp_mismatch_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign cs           = cs_q;
    assign spi_clk      = sclk_q;
    assign pico         = pico_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_mismatch = rsp_mismatch_q;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Scoreboard bench for spi_cfg_sequencer with a behavioural PSEC6 register
// file on the SPI pins and a pin monitor that logs each cs frame.
module tb_spi_cfg_sequencer;
    import psec6_spi_pkg::*;

    localparam int CLK_DIV    = 2;
    localparam int GAP_CYCLES = 8;
    localparam int FRAME_CYC  = CLK_DIV * 34;
    localparam int LAT_PLAIN  = 1 + FRAME_CYC;
    localparam int LAT_VERIFY = LAT_PLAIN + GAP_CYCLES + FRAME_CYC;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_write, req_verify;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_mismatch, busy, spi_clk, cs, pico, poci;
    logic [7:0] rsp_rdata;

    spi_cfg_sequencer #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_verify   (req_verify),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_mismatch (rsp_mismatch),
        .busy         (busy),
        .spi_clk      (spi_clk),
        .cs           (cs),
        .pico         (pico),
        .poci         (poci)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int testsRun    = 0;
    int testsFailed = 0;
    int rspCount    = 0;

    typedef struct {
        logic [7:0] rdata;
        logic       checkRdata;
        logic       mismatch;
        int         acceptCycle;
        int         latency;
    } exp_t;
    exp_t expQ[$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic failNow(input string name);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: bound expired or unexpected event", name);
    endtask

    // Behavioural register file: shifts pico on rising spi_clk, drives poci
    // just after falling spi_clk, commits a write only on the 16th bit.
    logic [7:0]  regs [0:15];
    logic        pllLocked = 1'b0;
    int          slBits;
    logic [15:0] slShift;
    logic        slRead;
    logic [6:0]  slAddr;
    logic [7:0]  slOut;

    initial begin : regFileModel
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        regs[ADDR_TRIGGER_MASK[3:0]] = 8'hFF;
        poci    = 1'b0;
        slBits  = 0;
        slShift = '0;
        slRead  = 1'b0;
        slAddr  = '0;
        slOut   = '0;
        forever begin
            @(posedge spi_clk or negedge spi_clk or negedge cs);
            if (!cs) begin
                slBits = 0;
                slRead = 1'b0;
                poci   = 1'b0;
            end else if (spi_clk) begin
                slShift = {slShift[14:0], pico};
                slBits++;
                if (slBits == 8) begin
                    slRead = (slShift[7] != RW_WRITE);
                    slAddr = slShift[6:0];
                    if (slAddr == ADDR_PLL_LOCKED) slOut = {7'b0, pllLocked};
                    else if (slAddr < 7'd12)       slOut = regs[slAddr[3:0]];
                    else                           slOut = 8'h00;
                end
                if (slBits == 16 && !slRead && slAddr != ADDR_PLL_LOCKED && slAddr < 7'd12)
                    regs[slAddr[3:0]] = slShift[7:0];
            end else begin
                #1;
                if (!cs) begin
                    slBits = 0;
                    slRead = 1'b0;
                    poci   = 1'b0;
                end else if (slRead && slBits >= 8 && slBits < 16) begin
                    poci = slOut[15 - slBits];
                end else begin
                    poci = 1'b0;
                end
            end
        end
    end

    // Pin monitor: logs frame contents, cs-high lengths and cs-low gaps.
    logic        prevSclk = 1'b0, prevCs = 1'b0, seenFrame = 1'b0;
    logic [15:0] curFrame = '0;
    int          curPulses = 0, csHighCnt = 0, csLowCnt = 0;
    logic [15:0] frameLog[$];
    int          lenLog[$];
    int          gapLog[$];

    initial begin : pinMonitor
        forever begin
            @(negedge clk);
            if (cs) begin
                if (!prevCs) begin
                    if (seenFrame) gapLog.push_back(csLowCnt);
                    csHighCnt = 0;
                    curFrame  = '0;
                    curPulses = 0;
                end
                csHighCnt++;
                if (spi_clk && !prevSclk) begin
                    curFrame = {curFrame[14:0], pico};
                    curPulses++;
                end
            end else begin
                if (prevCs) begin
                    frameLog.push_back(curFrame);
                    lenLog.push_back(csHighCnt);
                    seenFrame = 1'b1;
                    csLowCnt  = 0;
                end
                csLowCnt++;
            end
            prevSclk = spi_clk;
            prevCs   = cs;
        end
    end

    // Response monitor: pops the scoreboard on every rsp_valid pulse.
    initial begin : rspMonitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                rspCount++;
                if (expQ.size() == 0) begin
                    failNow("rsp_unexpected");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rsp_latency", cycle - e.acceptCycle, e.latency);
                    checkOutput("rsp_mismatch", int'(rsp_mismatch), int'(e.mismatch));
                    if (e.checkRdata) checkOutput("rsp_rdata", int'(rsp_rdata), int'(e.rdata));
                end
            end
        end
    end

    task automatic clearLogs();
        frameLog.delete();
        lenLog.delete();
        gapLog.delete();
        seenFrame = 1'b0;
    endtask

    // Starts at a negedge; drives the request and returns at the negedge after acceptance.
    task automatic applyStimulus(input logic wr, input logic vfy, input logic [6:0] addr,
                                 input logic [7:0] wdata, input logic expectRsp,
                                 input logic [7:0] expRdata, input logic checkRdata,
                                 input logic expMismatch, input int expLatency,
                                 output int acceptCycle);
        exp_t e;
        int   waited = 0;
        req_valid  = 1'b1;
        req_write  = wr;
        req_verify = vfy;
        req_addr   = addr;
        req_wdata  = wdata;
        acceptCycle = -1;
        while (!req_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            failNow("accept_timeout");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acceptCycle = cycle;
        if (expectRsp) begin
            e.rdata       = expRdata;
            e.checkRdata  = checkRdata;
            e.mismatch    = expMismatch;
            e.acceptCycle = acceptCycle;
            e.latency     = expLatency;
            expQ.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((busy || expQ.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy || expQ.size() != 0) failNow("idle_timeout");
        @(negedge clk);
    endtask

    task automatic checkFrame(input string name, input int idx, input logic [15:0] expected);
        if (frameLog.size() > idx) checkOutput(name, int'(frameLog[idx]), int'(expected));
        else                       failNow(name);
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : mainSeq
        int acc1, acc2, rspBefore;
        rst        = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_verify = 1'b0;
        req_addr   = 7'd4;
        req_wdata  = 8'h02;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("reset_pins", int'({cs, spi_clk, pico, rsp_valid, rsp_mismatch, busy, req_ready}), 1);
            checkOutput("reset_rdata", int'(rsp_rdata), 0);
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("release_ready", int'(req_ready), 1);
        checkOutput("release_busy", int'(busy), 0);

        $display("[TB] write addr 4 data 0x02");
        clearLogs();
        applyStimulus(1'b1, 1'b0, 7'd4, 8'h02, 1'b1, 8'h00, 1'b0, 1'b0, LAT_PLAIN, acc1);
        req_valid = 1'b0;
        waitIdle(1000);
        checkFrame("write_frame", 0, 16'h8402);
        if (lenLog.size() > 0) checkOutput("write_cs_len", lenLog[0], FRAME_CYC);
        checkOutput("write_mode_reg", int'(regs[4][1:0]), 2);

        $display("[TB] read addr 2 after reset");
        clearLogs();
        applyStimulus(1'b0, 1'b0, 7'd2, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, LAT_PLAIN, acc1);
        req_valid = 1'b0;
        waitIdle(1000);
        checkFrame("read_frame", 0, 16'h0200);

        $display("[TB] verified write to read-only addr 11");
        clearLogs();
        rspBefore = rspCount;
        applyStimulus(1'b1, 1'b1, 7'd11, 8'h01, 1'b1, 8'h00, 1'b1, 1'b1, LAT_VERIFY, acc1);
        req_valid = 1'b0;
        waitIdle(2000);
        checkOutput("verify_frames", frameLog.size(), 2);
        checkFrame("verify_wr_frame", 0, 16'h8B01);
        checkFrame("verify_rd_frame", 1, 16'h0B00);
        if (gapLog.size() > 0) checkOutput("verify_gap", gapLog[0], GAP_CYCLES);
        else                   failNow("verify_gap");
        checkOutput("verify_rsp_count", rspCount - rspBefore, 1);

        $display("[TB] verified write addr 3 data 0x5A");
        clearLogs();
        applyStimulus(1'b1, 1'b1, 7'd3, 8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0, LAT_VERIFY, acc1);
        req_valid = 1'b0;
        waitIdle(2000);
        checkFrame("verify_ok_rd_frame", 1, 16'h0300);

        $display("[TB] back-to-back writes");
        clearLogs();
        applyStimulus(1'b1, 1'b0, 7'd1, 8'h15, 1'b1, 8'h00, 1'b0, 1'b0, LAT_PLAIN, acc1);
        applyStimulus(1'b1, 1'b0, 7'd9, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, LAT_PLAIN, acc2);
        req_valid = 1'b0;
        waitIdle(1000);
        checkOutput("b2b_accept_spacing", acc2 - acc1, FRAME_CYC + GAP_CYCLES + 1);
        if (gapLog.size() > 0) checkOutput("b2b_gap_min", int'(gapLog[0] >= GAP_CYCLES), 1);
        else                   failNow("b2b_gap_min");
        checkFrame("b2b_frame1", 0, 16'h8115);
        checkFrame("b2b_frame2", 1, 16'h8900);
        checkOutput("b2b_vco_band", int'(regs[1][5:0]), 'h15);
        checkOutput("b2b_pll_switch", int'(regs[9][0]), 0);

        $display("[TB] abort write addr 2 during pulse 12");
        clearLogs();
        applyStimulus(1'b1, 1'b0, 7'd2, 8'h0F, 1'b0, 8'h00, 1'b0, 1'b0, 0, acc1);
        req_valid = 1'b0;
        begin
            int n = 0;
            while (!(cs && curPulses == 12) && n < 1000) begin
                @(negedge clk);
                n++;
            end
            if (!(cs && curPulses == 12)) failNow("abort_wait_pulse12");
        end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_cs", int'(cs), 0);
        checkOutput("abort_sclk_busy", int'({spi_clk, busy, req_ready}), 1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_trigger_mask", int'(regs[2]), 'hFF);
        applyStimulus(1'b0, 1'b0, 7'd2, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, LAT_PLAIN, acc1);
        req_valid = 1'b0;
        waitIdle(1000);

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_empty", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
